sha_uart_msg_rx: RTL and testbench
==================================

# sha_uart_msg_rx

Parametrised UART receive front-end for the SHA-over-UART datapath: deserialises UART frames with optional parity and packs received bytes big-endian into message words for the SHA core. It replaces the fixed 8N1 byte receiver with configurable baud divisor, parity mode and word width. It adds parity/framing/overrun reporting, a partial-word flush for message tails, and a ready/valid output handshake toward the SHA message loader.

## Interface
- CLKS_PER_BIT, 868, clk cycles per UART bit (≥ 8).
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- BYTES_PER_WORD, 4, bytes per output word (1..8); W = 8*BYTES_PER_WORD.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_uart_rx  in  1  serial line, idle high, asynchronous to clk.
- i_flush  in  1  single-cycle request to emit the partially filled word.
- o_word  out  W  packed word; first received byte in bits [W-1:W-8].
- o_word_nbytes  out  4  valid byte count in o_word (1..BYTES_PER_WORD).
- o_word_valid  out  1  o_word/o_word_nbytes valid; held until accepted.
- i_word_ready  in  1  consumer accepts the word when high with o_word_valid.
- o_parity_err  out  1  one-cycle pulse; frame had bad parity.
- o_frame_err  out  1  one-cycle pulse; stop bit sampled low.
- o_overrun  out  1  one-cycle pulse; good byte dropped because packer full.

## Operation
- i_uart_rx passes through a 2-FF synchroniser (both flops reset to 1).
- RX FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HIGH. Counters: bit-timer (clog2(CLKS_PER_BIT) bits), bit index (3 bits).
- IDLE: synced rx = 0 → START, timer cleared.
- START: at timer = CLKS_PER_BIT/2 − 1 (integer floor), rx = 0 → DATA with timer cleared; rx = 1 → IDLE (glitch, no error).
- DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 bits; then PAR if PARITY ≠ 0, else STOP.
- PAR: sample; check even/odd parity over 8 data bits + parity bit. The result is held until STOP.
- STOP: sample after CLKS_PER_BIT. Outcomes:
  - Stop = 1, parity OK: byte_done pulse, then IDLE.
  - Stop = 0: o_frame_err, byte dropped, → WAIT_HIGH.
  - Stop = 1, parity bad: o_parity_err, byte dropped, → IDLE.
  - Frame error takes precedence over parity error; only one error pulse per frame.
- WAIT_HIGH: stays until synced rx = 1, then IDLE. A break does not generate repeated frames.
- Packer: shift register plus byte count.
  - On byte_done the byte is appended at the LSB end: pack = {pack[W-9:0], byte}; count increments.
  - At count = BYTES_PER_WORD the pack is full. It transfers to the output register when the output is empty, or is being accepted the same cycle. Count then clears.
  - byte_done while the pack is full and cannot transfer: byte dropped, o_overrun pulses, pack unchanged.
- Flush, with count > 0: the pack is left-justified (shifted left by 8*(BYTES_PER_WORD − count)), low bytes are zero, and o_word_nbytes = count.
  - A flush is held pending until it can transfer.
  - A flush with count = 0 and no pending byte is ignored.
  - i_flush coinciding with byte_done: the byte is packed first and included in the flushed word.
- Output register: o_word_valid set on transfer, cleared on valid & ready; o_word and o_word_nbytes are stable while valid.
- Reset mid-frame: FSM → IDLE, pack and count cleared, output dropped.

## Timing
- Reset values: o_word = 0, o_word_nbytes = 0, o_word_valid = 0, all error pulses 0; FSM IDLE; synchroniser flops 1.
- Start-edge recognition: 2 cycles of synchroniser latency plus 1 cycle to leave IDLE.
- Stop sample at cycle S:
  - byte_done and error pulses registered high at S+1.
  - Pack updated at S+2.
  - o_word_valid high at S+3 when the output was free.
- Flush → o_word_valid: 2 cycles when the output is free.
- The output accepts one word per cycle. With ready held high, the packer never overruns.

## Test plan
- CLKS_PER_BIT=16, PARITY=0, BPW=4, ready=1: send 0x61,0x62,0x63,0x64 → one o_word_valid with o_word=0x61626364, nbytes=4, no errors.
- PARITY=1: send 0x07 with parity bit 0 → o_parity_err one pulse, no word. Resend 0x07 with parity 1 → byte accepted.
- Stop bit forced 0, then line held low for 40 bit times, then high → exactly one o_frame_err; FSM in WAIT_HIGH until high; next frame 0xA5 received normally.
- Send 0x01,0x02,0x03 then pulse i_flush → o_word=0x01020300, nbytes=3. Pulse i_flush again with count 0 → no word.
- ready=0: send 8 bytes 0x10..0x17 then a 9th byte 0x18 → first word 0x10111213 held valid, pack holds 0x14151617, 9th byte gives o_overrun. Raise ready → 0x10111213 then 0x14151617 delivered in consecutive cycles.
- 1-cycle low glitch on i_uart_rx in IDLE → no state change beyond START, no outputs. Assert rst mid-DATA → all outputs at reset values; next full frame received correctly.

Source files
------------

// File: rtl/sha_uart_msg_rx.sv
// UART receiver (8 data bits, optional parity) packing bytes big-endian into W-bit message words.
// Stop sample S: byte_done/errors at S+1, pack at S+2, o_word_valid at S+3; word held until i_word_ready, bytes dropped (o_overrun) when full pack is stalled.
module sha_uart_msg_rx #(
  parameter int CLKS_PER_BIT   = 868,
  parameter int PARITY         = 0,
  parameter int BYTES_PER_WORD = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_uart_rx,
  input  logic                          i_flush,
  output logic [8*BYTES_PER_WORD-1:0]   o_word,
  output logic [3:0]                    o_word_nbytes,
  output logic                          o_word_valid,
  input  logic                          i_word_ready,
  output logic                          o_parity_err,
  output logic                          o_frame_err,
  output logic                          o_overrun
);

  localparam int W  = 8 * BYTES_PER_WORD;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_T = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_T = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] CNT_FULL  = 4'(BYTES_PER_WORD);
  localparam logic ODD             = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HIGH
  } state_t;

  logic rx_meta, rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  state_t          state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [2:0]      bit_idx, bit_idx_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic            par_bad, par_bad_nxt;
  logic            byte_done, byte_done_nxt, perr_nxt, ferr_nxt;
  logic            tick_half, tick_full;

  assign tick_half = (timer == HALF_T);
  assign tick_full = (timer == FULL_T);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      par_bad      <= 1'b0;
      byte_done    <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      bit_idx      <= bit_idx_nxt;
      shreg        <= shreg_nxt;
      par_bad      <= par_bad_nxt;
      byte_done    <= byte_done_nxt;
      o_parity_err <= perr_nxt;
      o_frame_err  <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (!rx_s) state_nxt = S_START;
      S_START:     if (tick_half) state_nxt = rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (tick_full && bit_idx == 3'd7) state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:       if (tick_full) state_nxt = S_STOP;
      S_STOP:      if (tick_full) state_nxt = rx_s ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rx_s) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    timer_nxt     = timer + TW'(1);
    bit_idx_nxt   = bit_idx;
    shreg_nxt     = shreg;
    par_bad_nxt   = par_bad;
    byte_done_nxt = 1'b0;
    perr_nxt      = 1'b0;
    ferr_nxt      = 1'b0;
    case (state)
      S_IDLE: begin
        timer_nxt   = '0;
        bit_idx_nxt = '0;
        par_bad_nxt = 1'b0;
      end
      S_START: if (tick_half) timer_nxt = '0;
      S_DATA: if (tick_full) begin
        timer_nxt   = '0;
        shreg_nxt   = {rx_s, shreg[7:1]};
        bit_idx_nxt = bit_idx + 3'd1;
      end
      S_PAR: if (tick_full) begin
        timer_nxt   = '0;
        par_bad_nxt = (^{shreg, rx_s}) ^ ODD;
      end
      S_STOP: if (tick_full) begin
        timer_nxt = '0;
        // a low stop bit masks any parity result: one error pulse per frame
        if (!rx_s)        ferr_nxt      = 1'b1;
        else if (par_bad) perr_nxt      = 1'b1;
        else              byte_done_nxt = 1'b1;
      end
      default: timer_nxt = '0;
    endcase
  end

  logic [W-1:0] pack, pack_app, flush_word;
  logic [3:0]   count;
  logic [6:0]   shamt;
  logic         flush_pend, full, out_free, do_xfer;

  assign full       = (count == CNT_FULL);
  assign out_free   = !o_word_valid || i_word_ready;
  assign do_xfer    = out_free && (full || (flush_pend && count != 4'd0));
  assign pack_app   = (pack << 8) | W'(shreg);
  assign shamt      = 7'((BYTES_PER_WORD - int'(count)) * 8);
  assign flush_word = pack << shamt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pack          <= '0;
      count         <= '0;
      flush_pend    <= 1'b0;
      o_word        <= '0;
      o_word_nbytes <= '0;
      o_word_valid  <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (do_xfer) begin
        o_word        <= flush_word;
        o_word_nbytes <= count;
        o_word_valid  <= 1'b1;
        // a byte arriving on the transfer cycle starts the next word
        pack          <= byte_done ? W'(shreg) : '0;
        count         <= byte_done ? 4'd1 : 4'd0;
        flush_pend    <= i_flush && byte_done;
      end else begin
        if (o_word_valid && i_word_ready) o_word_valid <= 1'b0;
        if (byte_done) begin
          if (full) begin
            o_overrun <= 1'b1;
          end else begin
            pack  <= pack_app;
            count <= count + 4'd1;
          end
        end
        if (i_flush && (count != 4'd0 || byte_done)) flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sha_uart_msg_rx.sv
// Bench for sha_uart_msg_rx: a PARITY=0 and a PARITY=1 instance, scoreboarded against a byte-queue packing model.
module tb_sha_uart_msg_rx;
  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rx0, rx1, flush0, flush1, ready0, ready1;
  logic [31:0] word0, word1;
  logic [3:0] nb0, nb1;
  logic v0, v1, pe0, pe1, fe0, fe1, ov0, ov1;

  sha_uart_msg_rx #(.CLKS_PER_BIT(CPB), .PARITY(0), .BYTES_PER_WORD(4)) dut0 (
    .clk(clk), .rst(rst_n), .i_uart_rx(rx0), .i_flush(flush0), .o_word(word0),
    .o_word_nbytes(nb0), .o_word_valid(v0), .i_word_ready(ready0),
    .o_parity_err(pe0), .o_frame_err(fe0), .o_overrun(ov0));

  sha_uart_msg_rx #(.CLKS_PER_BIT(CPB), .PARITY(1), .BYTES_PER_WORD(4)) dut1 (
    .clk(clk), .rst(rst_n), .i_uart_rx(rx1), .i_flush(flush1), .o_word(word1),
    .o_word_nbytes(nb1), .o_word_valid(v1), .i_word_ready(ready1),
    .o_parity_err(pe1), .o_frame_err(fe1), .o_overrun(ov1));

  int vectors = 0, miscompares = 0, cyc = 0;
  int pe_cnt0 = 0, fe_cnt0 = 0, ov_cnt0 = 0, pe_cnt1 = 0, fe_cnt1 = 0, ov_cnt1 = 0;
  logic [35:0] q0[$], q1[$], exp0[$], exp1[$];
  logic [7:0]  mb0[$], mb1[$];
  int t0[$];
  bit rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (v0 && ready0) begin q0.push_back({nb0, word0}); t0.push_back(cyc); end
      if (v1 && ready1) q1.push_back({nb1, word1});
      if (pe0) pe_cnt0++;
      if (fe0) fe_cnt0++;
      if (ov0) ov_cnt0++;
      if (pe1) pe_cnt1++;
      if (fe1) fe_cnt1++;
      if (ov1) ov_cnt1++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx0 = v; else rx1 = v;
  endtask

  task automatic send_frame(input int which, input logic [7:0] b, input bit has_par,
                            input bit pbit, input bit sbit);
    set_rx(which, 1'b0); tick(CPB);
    for (int i = 0; i < 8; i++) begin set_rx(which, b[i]); tick(CPB); end
    if (has_par) begin set_rx(which, pbit); tick(CPB); end
    set_rx(which, sbit); tick(CPB);
    set_rx(which, 1'b1);
  endtask

  task automatic pulse_flush(input int which);
    if (which == 0) flush0 = 1'b1; else flush1 = 1'b1;
    tick(1);
    flush0 = 1'b0; flush1 = 1'b0;
  endtask

  // Reference: received bytes queue up; four make a word, a flush left-justifies the tail.
  task automatic model_flush(input int which);
    logic [7:0] b[$];
    logic [31:0] w;
    b = (which == 0) ? mb0 : mb1;
    if (b.size() == 0) return;
    w = '0;
    foreach (b[i]) w[31-8*i -: 8] = b[i];
    if (which == 0) begin exp0.push_back({4'(b.size()), w}); mb0.delete(); end
    else            begin exp1.push_back({4'(b.size()), w}); mb1.delete(); end
  endtask

  task automatic model_byte(input int which, input logic [7:0] b);
    if (which == 0) mb0.push_back(b); else mb1.push_back(b);
    if (((which == 0) ? mb0.size() : mb1.size()) == 4) model_flush(which);
  endtask

  task automatic test_reset;
    vectors++;
    if ({word0, nb0, v0, pe0, fe0, ov0} !== '0) begin
      miscompares++; $display("FAIL reset_dut0: got %h required 0", {word0, nb0, v0, pe0, fe0, ov0});
    end
    vectors++;
    if ({word1, nb1, v1, pe1, fe1, ov1} !== '0) begin
      miscompares++; $display("FAIL reset_dut1: got %h required 0", {word1, nb1, v1, pe1, fe1, ov1});
    end
    rst_n = 1'b1;
    tick(4 * CPB);
    vectors++;
    if ({v0, v1, pe0, fe0, ov0} !== 5'b0) begin
      miscompares++; $display("FAIL idle_after_reset: got %b required 0", {v0, v1, pe0, fe0, ov0});
    end
  endtask

  task automatic test_basic;
    logic [7:0] s[4] = '{8'h61, 8'h62, 8'h63, 8'h64};
    q0.delete();
    foreach (s[i]) send_frame(0, s[i], 0, 0, 1);
    tick(8);
    vectors++;
    if (q0.size() != 1) begin
      miscompares++; $display("FAIL basic_count: got %0d words required 1", q0.size());
    end else begin
      vectors++;
      if (q0[0] !== {4'd4, 32'h61626364}) begin
        miscompares++; $display("FAIL basic_word: got %h required %h", q0[0], {4'd4, 32'h61626364});
      end
    end
    vectors++;
    if (pe_cnt0 + fe_cnt0 + ov_cnt0 != 0) begin
      miscompares++; $display("FAIL basic_errors: got %0d required 0", pe_cnt0 + fe_cnt0 + ov_cnt0);
    end
  endtask

  task automatic test_random_stall;
    int n;
    logic [7:0] b;
    q0.delete(); exp0.delete(); mb0.delete();
    n = $urandom_range(5, 14);
    rand_rdy = 1'b1;
    fork
      begin
        while (rand_rdy) begin tick(1); ready0 = 1'($urandom_range(0, 1)); end
      end
    join_none
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      send_frame(0, b, 0, 0, 1);
      model_byte(0, b);
    end
    tick(4);
    pulse_flush(0);
    model_flush(0);
    tick(60);
    rand_rdy = 1'b0;
    tick(3);
    ready0 = 1'b1;
    tick(10);
    vectors++;
    if (q0.size() != exp0.size()) begin
      miscompares++; $display("FAIL rand_count: got %0d words required %0d", q0.size(), exp0.size());
    end
    for (int i = 0; i < exp0.size() && i < q0.size(); i++) begin
      vectors++;
      if (q0[i] !== exp0[i]) begin
        miscompares++; $display("FAIL rand_word[%0d]: got %h required %h", i, q0[i], exp0[i]);
      end
    end
  endtask

  task automatic test_parity;
    int bad = 0, pe_base;
    logic [7:0] b;
    bit good;
    q1.delete(); exp1.delete(); mb1.delete();
    pe_base = pe_cnt1;
    send_frame(1, 8'h07, 1, 1'b0, 1);
    tick(4);
    vectors++;
    if (pe_cnt1 - pe_base != 1) begin
      miscompares++; $display("FAIL parity_bad_pulse: got %0d pulses required 1", pe_cnt1 - pe_base);
    end
    send_frame(1, 8'h07, 1, 1'b1, 1);
    model_byte(1, 8'h07);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      good = 1'($urandom_range(0, 1));
      send_frame(1, b, 1, good ? ^b : ~^b, 1);
      if (good) model_byte(1, b); else bad++;
    end
    tick(4);
    pulse_flush(1);
    model_flush(1);
    tick(8);
    vectors++;
    if (pe_cnt1 - pe_base != bad + 1) begin
      miscompares++; $display("FAIL parity_err_count: got %0d required %0d", pe_cnt1 - pe_base, bad + 1);
    end
    vectors++;
    if (q1.size() != exp1.size()) begin
      miscompares++; $display("FAIL parity_words: got %0d required %0d", q1.size(), exp1.size());
    end
    for (int i = 0; i < exp1.size() && i < q1.size(); i++) begin
      vectors++;
      if (q1[i] !== exp1[i]) begin
        miscompares++; $display("FAIL parity_word[%0d]: got %h required %h", i, q1[i], exp1[i]);
      end
    end
  endtask

  task automatic test_frame_break;
    int fe_base, pe_base;
    q0.delete();
    fe_base = fe_cnt0; pe_base = pe_cnt0;
    send_frame(0, 8'h3C, 0, 0, 1'b0);
    rx0 = 1'b0;
    tick(40 * CPB);
    rx0 = 1'b1;
    tick(2 * CPB);
    vectors++;
    if (fe_cnt0 - fe_base != 1 || pe_cnt0 != pe_base || q0.size() != 0) begin
      miscompares++;
      $display("FAIL frame_break: got ferr=%0d perr=%0d words=%0d required 1/0/0",
               fe_cnt0 - fe_base, pe_cnt0 - pe_base, q0.size());
    end
    send_frame(0, 8'hA5, 0, 0, 1);
    tick(4);
    pulse_flush(0);
    tick(6);
    vectors++;
    if (q0.size() != 1 || q0[0] !== {4'd1, 32'hA500_0000}) begin
      miscompares++; $display("FAIL frame_recover: got %0d words first %h required %h",
                              q0.size(), (q0.size() > 0) ? q0[0] : 36'h0, {4'd1, 32'hA500_0000});
    end
  endtask

  task automatic test_flush;
    q0.delete();
    send_frame(0, 8'h01, 0, 0, 1);
    send_frame(0, 8'h02, 0, 0, 1);
    send_frame(0, 8'h03, 0, 0, 1);
    tick(4);
    pulse_flush(0);
    vectors++;
    if (v0 !== 1'b0) begin
      miscompares++; $display("FAIL flush_early: got valid %b required 0", v0);
    end
    tick(1);
    vectors++;
    if ({v0, nb0, word0} !== {1'b1, 4'd3, 32'h0102_0300}) begin
      miscompares++; $display("FAIL flush_word: got %h required %h", {v0, nb0, word0}, {1'b1, 4'd3, 32'h0102_0300});
    end
    tick(3);
    pulse_flush(0);
    tick(8);
    vectors++;
    if (q0.size() != 1) begin
      miscompares++; $display("FAIL flush_empty: got %0d words required 1", q0.size());
    end
  endtask

  task automatic test_back_to_back;
    int ov_base;
    q0.delete(); t0.delete();
    ov_base = ov_cnt0;
    ready0 = 1'b0;
    for (int i = 0; i < 9; i++) send_frame(0, 8'h10 + 8'(i), 0, 0, 1);
    tick(4);
    vectors++;
    if ({v0, nb0, word0} !== {1'b1, 4'd4, 32'h1011_1213}) begin
      miscompares++; $display("FAIL stall_hold: got %h required %h", {v0, nb0, word0}, {1'b1, 4'd4, 32'h1011_1213});
    end
    vectors++;
    if (ov_cnt0 - ov_base != 1) begin
      miscompares++; $display("FAIL overrun_pulse: got %0d required 1", ov_cnt0 - ov_base);
    end
    ready0 = 1'b1;
    tick(4);
    vectors++;
    if (q0.size() != 2 || q0[0] !== {4'd4, 32'h1011_1213} || q0[1] !== {4'd4, 32'h1415_1617}) begin
      miscompares++; $display("FAIL drain_words: got %0d words %h %h required 2 words %h %h", q0.size(),
                              (q0.size() > 0) ? q0[0] : 36'h0, (q0.size() > 1) ? q0[1] : 36'h0,
                              {4'd4, 32'h1011_1213}, {4'd4, 32'h1415_1617});
    end else begin
      vectors++;
      if (t0[1] - t0[0] != 1) begin
        miscompares++; $display("FAIL drain_spacing: got %0d cycles required 1", t0[1] - t0[0]);
      end
    end
  endtask

  task automatic test_glitch_reset;
    int errs;
    q0.delete();
    errs = pe_cnt0 + fe_cnt0 + ov_cnt0;
    rx0 = 1'b0; tick(1); rx0 = 1'b1;
    tick(3 * CPB);
    vectors++;
    if (pe_cnt0 + fe_cnt0 + ov_cnt0 != errs || v0 !== 1'b0 || q0.size() != 0) begin
      miscompares++; $display("FAIL glitch: got errs=%0d valid=%b words=%0d required none",
                              pe_cnt0 + fe_cnt0 + ov_cnt0 - errs, v0, q0.size());
    end
    ready0 = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(0, 8'h20 + 8'(i), 0, 0, 1);
    tick(4);
    vectors++;
    if ({v0, word0} !== {1'b1, 32'h2021_2223}) begin
      miscompares++; $display("FAIL pre_reset_word: got %h required %h", {v0, word0}, {1'b1, 32'h2021_2223});
    end
    rx0 = 1'b0; tick(CPB);
    rx0 = 1'b0; tick(CPB);
    rx0 = 1'b1; tick(CPB);
    rst_n = 1'b0;
    tick(2);
    vectors++;
    if ({word0, nb0, v0, pe0, fe0, ov0} !== '0) begin
      miscompares++; $display("FAIL mid_frame_reset: got %h required 0", {word0, nb0, v0, pe0, fe0, ov0});
    end
    rx0 = 1'b1;
    rst_n = 1'b1;
    ready0 = 1'b1;
    tick(2 * CPB);
    send_frame(0, 8'h5A, 0, 0, 1);
    tick(4);
    pulse_flush(0);
    tick(6);
    vectors++;
    if (q0.size() != 1 || q0[0] !== {4'd1, 32'h5A00_0000}) begin
      miscompares++; $display("FAIL post_reset_frame: got %0d words first %h required %h",
                              q0.size(), (q0.size() > 0) ? q0[0] : 36'h0, {4'd1, 32'h5A00_0000});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1;
    flush0 = 1'b0; flush1 = 1'b0;
    ready0 = 1'b1; ready1 = 1'b1;
    tick(5);
    test_reset;
    test_basic;
    test_random_stall;
    test_parity;
    test_frame_break;
    test_flush;
    test_back_to_back;
    test_glitch_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
